pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on posedge.
REQ-002 SHALL have port RST_N, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port stallreq_if, input, 1, IF stage stall request, level.
REQ-004 SHALL have port stallreq_id, input, 1, ID stage stall request (load-use), level.
REQ-005 SHALL have port stallreq_ex, input, 1, EX stage stall request, level.
REQ-006 SHALL have port stallreq_mem, input, 1, MEM stage stall request, level.
REQ-007 SHALL have port multi_start, input, 1, one-cycle pulse starting a multi-cycle EX operation.
REQ-008 SHALL have port multi_len, input, 6, EX operation length in cycles, sampled with multi_start.
REQ-009 SHALL have port flush_req, input, 1, pipeline flush request pulse.
REQ-010 SHALL have port flush_pc, input, 32, redirect target, sampled with flush_req.
REQ-011 SHALL have port stall, output, 6, per-stage hold vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-012 SHALL have port flush, output, 1, registered one-cycle flush pulse to all pipeline registers.
REQ-013 SHALL have port new_pc, output, 32, registered redirect target, valid while flush=1.
REQ-014 SHALL have port multi_done, output, 1, pulse on last cycle of a multi-cycle EX operation.
REQ-015 SHALL have port stall_timeout, output, 1, sticky watchdog flag.

Function
REQ-016 SHALL compute stall combinationally from requests and state, deepest requester winning: MEM -> 011111; EX or multi active -> 001111; ID -> 000111; IF -> 000011; none -> 000000.
REQ-017 SHALL keep stall[5] at 0 under all conditions.
REQ-018 SHALL implement FSM states IDLE, MULTI, FLUSH, encoded in 2 bits.
REQ-019 IDLE: flush_req -> FLUSH; else multi_start with effective length N>=2 -> MULTI with cnt=N-1; else stay.
REQ-020 SHALL treat multi_len=0 as N=1; N=1 stalls EX only in the start cycle, asserts multi_done in that cycle, and stays in IDLE.
REQ-021 multi_start with length N SHALL hold stall>=001111 for exactly N consecutive cycles, counted from the start cycle inclusive.
REQ-022 MULTI: stall>=001111; cnt decrements every cycle; multi_done=1 and next state IDLE when cnt==1.
REQ-023 multi_start received in MULTI or FLUSH SHALL be ignored.
REQ-024 flush_req in cycle T SHALL produce flush=1 and new_pc=flush_pc in cycle T+1 only.
REQ-025 In the FLUSH cycle, stall SHALL be 000000 regardless of requests; the next state is IDLE unless flush_req is high again, in which case FLUSH repeats.
REQ-026 flush_req in MULTI SHALL abort the operation: cnt cleared, no multi_done, next state FLUSH.
REQ-027 flush_req takes priority over multi_start in the same cycle; that multi_start is dropped.
REQ-028 new_pc SHALL hold its last value while flush=0.
REQ-029 multi_done and flush SHALL never be 1 in the same cycle.

Reset
REQ-030 While RST_N=0, outputs SHALL be: state IDLE, cnt 0, stall 000000, flush 0, new_pc 0, multi_done 0, stall_timeout 0, watchdog count 0.
REQ-031 Reset assertion mid-MULTI or mid-FLUSH SHALL abort immediately, without waiting for CLK.
REQ-032 The first posedge after RST_N rises SHALL be treated as a normal IDLE cycle.

Configuration
REQ-033 Macro PIPE_CTRL_WDOG_EN SHALL control the stall watchdog.
REQ-034 With the macro defined: a 10-bit counter increments each cycle stall!=0, clears when stall==0, and saturates at 1023; reaching 1023 sets stall_timeout, which stays set until reset.
REQ-035 Without the macro: no counter is built and stall_timeout is tied to 0.

Verification
REQ-036 Bench SHALL cover: stallreq_id=1 and stallreq_mem=1 in the same cycle -> stall=011111; only stallreq_if=1 -> stall=000011.
REQ-037 Bench SHALL cover: multi_start with multi_len=5 at cycle 10 -> stall=001111 in cycles 10-14, multi_done=1 in cycle 14 only, stall=000000 in cycle 15.
REQ-038 Bench SHALL cover: multi_len=0 and multi_len=1 -> one stall cycle with multi_done in the same cycle.
REQ-039 Bench SHALL cover: multi_len=8 at cycle 0 and flush_req with flush_pc=0x00001000 at cycle 3 -> flush=1 and new_pc=0x00001000 at cycle 4, stall=000000 at cycle 4, no multi_done.
REQ-040 Bench SHALL cover: RST_N pulled low mid-MULTI between clock edges -> all outputs 0 before the next posedge.
REQ-041 Bench SHALL cover: with PIPE_CTRL_WDOG_EN, stallreq_ex held for 1100 cycles -> stall_timeout rises after 1023 stalled cycles and remains 1 after the request drops.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller with per-stage stall vector, multi-cycle EX sequencing and flush redirect.
// Optional stall watchdog built when PIPE_CTRL_WDOG_EN is defined; otherwise stall_timeout is tied low.
module pipe_ctrl (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        multi_start,
    input  logic [5:0]  multi_len,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        multi_done,
    output logic        stall_timeout
);
    localparam int unsigned STAGES = 6;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned PC_W   = 32;

    localparam logic [STAGES-1:0] HOLD_MEM  = 6'b011111;
    localparam logic [STAGES-1:0] HOLD_EX   = 6'b001111;
    localparam logic [STAGES-1:0] HOLD_ID   = 6'b000111;
    localparam logic [STAGES-1:0] HOLD_IF   = 6'b000011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULTI = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_nxt;
    logic              ex_busy;
    logic              done_c;
    logic [STAGES-1:0] hold_c;

    // Next state and EX-operation sequencing; a flush always wins over a new or running operation.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ex_busy   = 1'b0;
        done_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush_req) begin
                    state_nxt = ST_FLUSH;
                end else if (multi_start) begin
                    ex_busy = 1'b1;
                    if (multi_len <= LEN_W'(1)) begin
                        done_c = 1'b1;
                    end else begin
                        state_nxt = ST_MULTI;
                        cnt_nxt   = multi_len - LEN_W'(1);
                    end
                end
            end
            ST_MULTI: begin
                ex_busy = 1'b1;
                if (flush_req) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = '0;
                end else if (cnt == LEN_W'(1)) begin
                    done_c    = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - LEN_W'(1);
                end
            end
            ST_FLUSH: begin
                state_nxt = flush_req ? ST_FLUSH : ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Deepest requester wins; nothing is held while the flush pulse is out.
    always_comb begin
        hold_c = '0;
        if (state != ST_FLUSH) begin
            if (stallreq_mem) begin
                hold_c = HOLD_MEM;
            end else if (stallreq_ex || ex_busy) begin
                hold_c = HOLD_EX;
            end else if (stallreq_id) begin
                hold_c = HOLD_ID;
            end else if (stallreq_if) begin
                hold_c = HOLD_IF;
            end
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign stall      = RST_N ? hold_c : '0;
    assign multi_done = RST_N & done_c;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            flush  <= 1'b0;
            new_pc <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            flush <= flush_req;
            if (flush_req) begin
                new_pc <= PC_W'(flush_pc);
            end
        end
    end

`ifdef PIPE_CTRL_WDOG_EN
    localparam int unsigned WDOG_W = 10;

    logic [WDOG_W-1:0] wdog_cnt;
    logic [WDOG_W-1:0] wdog_nxt;
    logic              timeout_q;

    // Run length of consecutive stalled cycles, saturating at all-ones.
    always_comb begin
        wdog_nxt = wdog_cnt;
        if (hold_c == '0) begin
            wdog_nxt = '0;
        end else if (wdog_cnt != '1) begin
            wdog_nxt = wdog_cnt + WDOG_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_cnt  <= wdog_nxt;
            timeout_q <= timeout_q | (wdog_nxt == '1);
        end
    end

    assign stall_timeout = timeout_q;
`else
    assign stall_timeout = 1'b0;
`endif

endmodule
